// File: rtl/t5_bus_arb_pkg.sv
// -----------------------------------------------------------------------------
// t5_pkg
// Shared definitions for the fetch/load-store Wishbone arbiter.
//   XLEN_DEF : default data/address width
//   arb_st_e : arbiter state encoding (idle, fetch granted, data granted)
// -----------------------------------------------------------------------------
package t5_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_IGNT = 2'd1,
      ST_DGNT = 2'd2
   } arb_st_e;

endpackage

// File: rtl/t5_bus_arb.sv
// -----------------------------------------------------------------------------
// t5_bus_arb
// Shares one external Wishbone master port between instruction fetch (iwb_*)
// and the load/store unit (dwb_*). One requester is granted at a time and keeps
// the grant until ack, abort (strobe dropped) or watchdog timeout. Under
// contention the master not served last wins.
//
// State table
//   state   | meaning
//   ST_IDLE | no grant; arbitrate pending strobes for the next cycle
//   ST_IGNT | fetch master owns the shared bus
//   ST_DGNT | data master owns the shared bus
//
// Ports
//   sclk, srst          clock, async active-low reset
//   iwb_*               fetch master (adr/stb in, ack/dti out)
//   dwb_*               data master (adr/dto/sel/wre/stb in, ack/dti out)
//   bwb_*               shared bus master port (dti/ack in, rest out)
//   berr                one-cycle pulse when the watchdog ends a transfer
// -----------------------------------------------------------------------------
module t5_bus_arb
   import t5_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int TOUT = 16
) (
   input  logic            sclk,
   input  logic            srst,
   input  logic [XLEN-3:0] iwb_adr,
   input  logic            iwb_stb,
   output logic            iwb_ack,
   output logic [XLEN-1:0] iwb_dti,
   input  logic [XLEN-3:0] dwb_adr,
   input  logic [XLEN-1:0] dwb_dto,
   input  logic [3:0]      dwb_sel,
   input  logic            dwb_wre,
   input  logic            dwb_stb,
   output logic            dwb_ack,
   output logic [XLEN-1:0] dwb_dti,
   output logic [XLEN-3:0] bwb_adr,
   output logic [XLEN-1:0] bwb_dto,
   output logic [3:0]      bwb_sel,
   output logic            bwb_wre,
   output logic            bwb_stb,
   output logic            bwb_cyc,
   input  logic [XLEN-1:0] bwb_dti,
   input  logic            bwb_ack,
   output logic            berr
);

   // Counter keeps at least one bit so TOUT=0 still elaborates; it is held at 0.
   localparam int CW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;

   arb_st_e       r_st,  w_st_nxt;
   logic          r_lst, w_lst_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;

   logic w_ignt;
   logic w_dgnt;
   logic w_gnt_stb;
   logic w_tout;

   assign w_ignt    = (r_st == ST_IGNT);
   assign w_dgnt    = (r_st == ST_DGNT);
   assign w_gnt_stb = (w_ignt & iwb_stb) | (w_dgnt & dwb_stb);

   // A real ack in the limit cycle wins over the watchdog; an aborted
   // transfer (strobe already gone) is not timed out.
   assign w_tout = (TOUT != 0) && w_gnt_stb && !bwb_ack &&
                   (r_cnt == CW'(TOUT - 1));

   always_ff @(posedge sclk or negedge srst) begin
      if (!srst) begin
         r_st  <= ST_IDLE;
         r_lst <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_st  <= w_st_nxt;
         r_lst <= w_lst_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_st_nxt  = r_st;
      w_lst_nxt = r_lst;
      w_cnt_nxt = r_cnt;
      case (r_st)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            // lst=0 means fetch was served last, so data wins a tie.
            if (dwb_stb && (!iwb_stb || !r_lst))
               w_st_nxt = ST_DGNT;
            else if (iwb_stb)
               w_st_nxt = ST_IGNT;
         end
         ST_IGNT, ST_DGNT: begin
            if (bwb_ack || w_tout) begin
               w_st_nxt  = ST_IDLE;
               w_lst_nxt = w_dgnt;
               w_cnt_nxt = '0;
            end else if (!w_gnt_stb) begin
               w_st_nxt  = ST_IDLE;
               w_cnt_nxt = '0;
            end else if (TOUT != 0) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_st_nxt  = ST_IDLE;
            w_cnt_nxt = '0;
         end
      endcase
   end

   assign bwb_cyc = w_ignt | w_dgnt;
   assign bwb_stb = w_gnt_stb;
   assign bwb_adr = w_dgnt ? dwb_adr : iwb_adr;
   assign bwb_dto = dwb_dto;
   assign bwb_sel = w_dgnt ? dwb_sel : (w_ignt ? 4'hF : 4'h0);
   assign bwb_wre = w_dgnt & dwb_wre;

   assign iwb_ack = w_ignt & (bwb_ack | w_tout);
   assign dwb_ack = w_dgnt & (bwb_ack | w_tout);

   // A timed-out master receives zero data rather than whatever is on the bus.
   assign iwb_dti = (w_ignt & w_tout) ? '0 : bwb_dti;
   assign dwb_dti = (w_dgnt & w_tout) ? '0 : bwb_dti;

   assign berr = w_tout;

endmodule

// File: tb/tb_t5_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_t5_bus_arb
// Directed scenarios plus a randomized run checked against a transaction-level
// model of the arbitration rules (owner, last served, grant age).
// -----------------------------------------------------------------------------
module tb_t5_bus_arb;

   localparam int XLEN    = 32;
   localparam int TB_TOUT = 4;

   logic            sclk = 1'b0;
   logic            srst = 1'b0;
   logic [XLEN-3:0] iwb_adr = '0;
   logic            iwb_stb = 1'b0;
   logic            iwb_ack;
   logic [XLEN-1:0] iwb_dti;
   logic [XLEN-3:0] dwb_adr = '0;
   logic [XLEN-1:0] dwb_dto = '0;
   logic [3:0]      dwb_sel = '0;
   logic            dwb_wre = 1'b0;
   logic            dwb_stb = 1'b0;
   logic            dwb_ack;
   logic [XLEN-1:0] dwb_dti;
   logic [XLEN-3:0] bwb_adr;
   logic [XLEN-1:0] bwb_dto;
   logic [3:0]      bwb_sel;
   logic            bwb_wre;
   logic            bwb_stb;
   logic            bwb_cyc;
   logic [XLEN-1:0] bwb_dti = '0;
   logic            bwb_ack = 1'b0;
   logic            berr;

   int checks = 0;
   int errors = 0;

   always #5 sclk = ~sclk;

   t5_bus_arb #(.XLEN(XLEN), .TOUT(TB_TOUT)) dut (
      .sclk(sclk), .srst(srst),
      .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_ack(iwb_ack), .iwb_dti(iwb_dti),
      .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel), .dwb_wre(dwb_wre),
      .dwb_stb(dwb_stb), .dwb_ack(dwb_ack), .dwb_dti(dwb_dti),
      .bwb_adr(bwb_adr), .bwb_dto(bwb_dto), .bwb_sel(bwb_sel), .bwb_wre(bwb_wre),
      .bwb_stb(bwb_stb), .bwb_cyc(bwb_cyc), .bwb_dti(bwb_dti), .bwb_ack(bwb_ack),
      .berr(berr)
   );

   // ---------------- reference model ----------------
   // m_own: 0 = bus free, 1 = fetch owns it, 2 = data owns it
   // m_last: master served last (1 fetch, 2 data); m_age: grant cycles so far
   int m_own  = 0;
   int m_last = 1;
   int m_age  = 0;

   function automatic logic m_req_of(int who);
      return (who == 1) ? iwb_stb : (who == 2) ? dwb_stb : 1'b0;
   endfunction

   function automatic logic m_timeout();
      return (m_own != 0) && (TB_TOUT > 0) && (m_age + 1 == TB_TOUT) &&
             !bwb_ack && m_req_of(m_own);
   endfunction

   always @(posedge sclk or negedge srst) begin
      if (!srst) begin
         m_own  <= 0;
         m_last <= 1;
         m_age  <= 0;
      end else if (m_own != 0) begin
         if (bwb_ack || m_timeout()) begin
            m_last <= m_own;
            m_own  <= 0;
            m_age  <= 0;
         end else if (!m_req_of(m_own)) begin
            m_own <= 0;
            m_age <= 0;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (iwb_stb && dwb_stb) begin
         m_own <= (m_last == 2) ? 1 : 2;
      end else if (dwb_stb) begin
         m_own <= 2;
      end else if (iwb_stb) begin
         m_own <= 1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic do_reset();
      srst = 1'b0; iwb_stb = 1'b0; dwb_stb = 1'b0; bwb_ack = 1'b0;
      repeat (2) @(posedge sclk);
      #1 srst = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      srst = 1'b0;
      iwb_stb = 1'b1; dwb_stb = 1'b1; bwb_ack = 1'b1;
      @(negedge sclk);
      checks++; if (bwb_cyc !== 1'b0) begin errors++; $display("FAIL rst_cyc got %b exp 0", bwb_cyc); end
      checks++; if (bwb_stb !== 1'b0) begin errors++; $display("FAIL rst_stb got %b exp 0", bwb_stb); end
      checks++; if ({iwb_ack, dwb_ack, berr} !== 3'b000) begin errors++; $display("FAIL rst_acks got %b exp 000", {iwb_ack, dwb_ack, berr}); end
      checks++; if (bwb_wre !== 1'b0) begin errors++; $display("FAIL rst_wre got %b exp 0", bwb_wre); end
      do_reset();
   endtask

   task automatic test_single_write();
      dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_adr = 30'h100; dwb_sel = 4'h3; dwb_dto = 32'hA5A5_0001;
      @(negedge sclk);
      checks++; if (bwb_stb !== 1'b0) begin errors++; $display("FAIL t1_latency got %b exp 0", bwb_stb); end
      tick();
      @(negedge sclk);
      checks++; if ({bwb_cyc, bwb_stb, bwb_wre} !== 3'b111) begin errors++; $display("FAIL t1_ctl got %b exp 111", {bwb_cyc, bwb_stb, bwb_wre}); end
      checks++; if (bwb_sel !== 4'h3) begin errors++; $display("FAIL t1_sel got %h exp 3", bwb_sel); end
      checks++; if (bwb_adr !== 30'h100) begin errors++; $display("FAIL t1_adr got %h exp 100", bwb_adr); end
      checks++; if (bwb_dto !== 32'hA5A5_0001) begin errors++; $display("FAIL t1_dto got %h exp a5a50001", bwb_dto); end
      checks++; if (dwb_ack !== 1'b0) begin errors++; $display("FAIL t1_early_ack got %b exp 0", dwb_ack); end
      tick();
      bwb_ack = 1'b1;
      @(negedge sclk);
      checks++; if ({dwb_ack, iwb_ack, berr} !== 3'b100) begin errors++; $display("FAIL t1_ack got %b exp 100", {dwb_ack, iwb_ack, berr}); end
      tick();
      bwb_ack = 1'b0; dwb_stb = 1'b0;
      @(negedge sclk);
      checks++; if ({bwb_cyc, dwb_ack} !== 2'b00) begin errors++; $display("FAIL t1_after got %b exp 00", {bwb_cyc, dwb_ack}); end
      tick();
   endtask

   task automatic test_alternate();
      do_reset();
      iwb_stb = 1'b1; iwb_adr = 30'h2000;
      dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_adr = 30'h3000; dwb_sel = 4'hC;
      for (int k = 0; k < 8; k++) begin
         int exp_own;
         #1 bwb_ack = bwb_stb;
         exp_own = (k % 2 == 0) ? 0 : (((k / 2) % 2 == 0) ? 2 : 1);
         @(negedge sclk);
         checks++; if (bwb_cyc !== (exp_own != 0)) begin errors++; $display("FAIL t2_cyc k=%0d got %b exp %b", k, bwb_cyc, exp_own != 0); end
         checks++; if ({iwb_ack, dwb_ack} !== {exp_own == 1, exp_own == 2}) begin errors++; $display("FAIL t2_ack k=%0d got %b exp %b", k, {iwb_ack, dwb_ack}, {exp_own == 1, exp_own == 2}); end
         if (exp_own != 0) begin
            checks++; if (bwb_adr !== ((exp_own == 2) ? 30'h3000 : 30'h2000)) begin errors++; $display("FAIL t2_adr k=%0d got %h", k, bwb_adr); end
         end
         tick();
      end
      iwb_stb = 1'b0; dwb_stb = 1'b0; bwb_ack = 1'b0;
      tick();
   endtask

   task automatic test_fetch_read();
      iwb_stb = 1'b1; iwb_adr = 30'h40; dwb_wre = 1'b1;
      tick();
      bwb_ack = 1'b1; bwb_dti = 32'hDEAD_BEEF;
      @(negedge sclk);
      checks++; if (iwb_dti !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t3_dti got %h exp deadbeef", iwb_dti); end
      checks++; if ({iwb_ack, dwb_ack} !== 2'b10) begin errors++; $display("FAIL t3_ack got %b exp 10", {iwb_ack, dwb_ack}); end
      checks++; if ({bwb_wre, bwb_sel} !== 5'b0_1111) begin errors++; $display("FAIL t3_wre_sel got %b exp 01111", {bwb_wre, bwb_sel}); end
      checks++; if (bwb_adr !== 30'h40) begin errors++; $display("FAIL t3_adr got %h exp 40", bwb_adr); end
      tick();
      iwb_stb = 1'b0; bwb_ack = 1'b0;
      @(negedge sclk);
      checks++; if (iwb_ack !== 1'b0) begin errors++; $display("FAIL t3_ack_once got %b exp 0", iwb_ack); end
      tick();
   endtask

   task automatic test_timeout();
      dwb_stb = 1'b1; dwb_wre = 1'b0; bwb_dti = 32'h1234_5678;
      tick();
      for (int g = 1; g <= TB_TOUT; g++) begin
         @(negedge sclk);
         checks++; if (bwb_cyc !== 1'b1) begin errors++; $display("FAIL t4_cyc g=%0d got %b exp 1", g, bwb_cyc); end
         checks++; if ({dwb_ack, berr} !== ((g == TB_TOUT) ? 2'b11 : 2'b00)) begin errors++; $display("FAIL t4_to g=%0d got %b exp %b", g, {dwb_ack, berr}, (g == TB_TOUT) ? 2'b11 : 2'b00); end
         if (g == TB_TOUT) begin
            checks++; if (dwb_dti !== 32'h0) begin errors++; $display("FAIL t4_dti got %h exp 0", dwb_dti); end
            checks++; if ({iwb_ack, iwb_dti} !== {1'b0, 32'h1234_5678}) begin errors++; $display("FAIL t4_other got %b/%h", iwb_ack, iwb_dti); end
         end
         tick();
      end
      dwb_stb = 1'b0;
      @(negedge sclk);
      checks++; if ({bwb_cyc, berr} !== 2'b00) begin errors++; $display("FAIL t4_idle got %b exp 00", {bwb_cyc, berr}); end
      tick();
   endtask

   task automatic test_abort();
      dwb_stb = 1'b1; dwb_wre = 1'b1; iwb_stb = 1'b0; iwb_adr = 30'h77;
      tick();
      iwb_stb = 1'b1;
      tick();
      dwb_stb = 1'b0;
      @(negedge sclk);
      checks++; if ({bwb_cyc, bwb_stb, dwb_ack} !== 3'b100) begin errors++; $display("FAIL t5_drop got %b exp 100", {bwb_cyc, bwb_stb, dwb_ack}); end
      tick();
      @(negedge sclk);
      checks++; if (bwb_cyc !== 1'b0) begin errors++; $display("FAIL t5_idle got %b exp 0", bwb_cyc); end
      tick();
      bwb_ack = 1'b1;
      @(negedge sclk);
      checks++; if ({bwb_cyc, bwb_wre, bwb_adr, iwb_ack} !== {1'b1, 1'b0, 30'h77, 1'b1}) begin errors++; $display("FAIL t5_fetch got %b/%b/%h/%b", bwb_cyc, bwb_wre, bwb_adr, iwb_ack); end
      tick();
      iwb_stb = 1'b0; bwb_ack = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      dwb_stb = 1'b1; dwb_wre = 1'b1; dwb_adr = 30'h55;
      tick();
      tick();
      bwb_ack = 1'b1;
      #1 srst = 1'b0;
      #1;
      checks++; if ({bwb_stb, bwb_cyc, dwb_ack} !== 3'b000) begin errors++; $display("FAIL t6_async got %b exp 000", {bwb_stb, bwb_cyc, dwb_ack}); end
      bwb_ack = 1'b0;
      tick();
      iwb_stb = 1'b1; iwb_adr = 30'h66;
      srst = 1'b1;
      tick();
      @(negedge sclk);
      checks++; if ({bwb_cyc, bwb_wre, bwb_adr} !== {1'b1, 1'b1, 30'h55}) begin errors++; $display("FAIL t6_first got %b/%b/%h exp D grant", bwb_cyc, bwb_wre, bwb_adr); end
      iwb_stb = 1'b0; dwb_stb = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_random();
      logic i_req = 1'b0, d_req = 1'b0, i_seen = 1'b0, d_seen = 1'b0;
      int s_dly = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic e_gstb, e_to, e_iack, e_dack;
         if (i_req && i_seen) i_req = 1'b0;
         if (d_req && d_seen) d_req = 1'b0;
         if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req = 1'b1; iwb_adr = 30'($urandom);
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1'b1; dwb_adr = 30'($urandom); dwb_dto = $urandom;
            dwb_sel = 4'($urandom); dwb_wre = 1'($urandom);
         end
         iwb_stb = i_req; dwb_stb = d_req;
         if (m_own != 0 && m_age == 0) begin
            s_dly = $urandom_range(0, 5);
            if (s_dly == 5) s_dly = 99;
         end
         bwb_ack = (m_own != 0) && (m_age >= s_dly);
         bwb_dti = $urandom;
         @(negedge sclk);
         e_gstb = m_req_of(m_own);
         e_to   = m_timeout();
         e_iack = (m_own == 1) && (bwb_ack || e_to);
         e_dack = (m_own == 2) && (bwb_ack || e_to);
         checks++; if (bwb_cyc !== (m_own != 0)) begin errors++; $display("FAIL rnd_cyc c=%0d got %b exp %b", c, bwb_cyc, m_own != 0); end
         checks++; if (bwb_stb !== e_gstb) begin errors++; $display("FAIL rnd_stb c=%0d got %b exp %b", c, bwb_stb, e_gstb); end
         checks++; if ({iwb_ack, dwb_ack} !== {e_iack, e_dack}) begin errors++; $display("FAIL rnd_ack c=%0d got %b exp %b", c, {iwb_ack, dwb_ack}, {e_iack, e_dack}); end
         checks++; if (berr !== e_to) begin errors++; $display("FAIL rnd_berr c=%0d got %b exp %b", c, berr, e_to); end
         checks++; if (iwb_dti !== ((m_own == 1 && e_to) ? 32'h0 : bwb_dti)) begin errors++; $display("FAIL rnd_idti c=%0d got %h", c, iwb_dti); end
         checks++; if (dwb_dti !== ((m_own == 2 && e_to) ? 32'h0 : bwb_dti)) begin errors++; $display("FAIL rnd_ddti c=%0d got %h", c, dwb_dti); end
         if (m_own != 0) begin
            checks++; if (bwb_adr !== ((m_own == 2) ? dwb_adr : iwb_adr)) begin errors++; $display("FAIL rnd_adr c=%0d got %h", c, bwb_adr); end
            checks++; if (bwb_wre !== ((m_own == 2) ? dwb_wre : 1'b0)) begin errors++; $display("FAIL rnd_wre c=%0d got %b", c, bwb_wre); end
            checks++; if (bwb_sel !== ((m_own == 2) ? dwb_sel : 4'hF)) begin errors++; $display("FAIL rnd_sel c=%0d got %h", c, bwb_sel); end
         end
         i_seen = iwb_ack;
         d_seen = dwb_ack;
         tick();
      end
      iwb_stb = 1'b0; dwb_stb = 1'b0; bwb_ack = 1'b0;
      tick();
   endtask

   initial begin
      #1;
      test_reset();
      test_single_write();
      test_alternate();
      test_fetch_read();
      test_timeout();
      test_abort();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
